// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter for the async FIFO write port.
// Every beat is gated on fifo_full; fifo_overflow is latched as sticky status.
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  input  logic                   fifo_overflow,
  output logic                   fifo_wen,
  output logic [DATA_W-1:0]      fifo_wdata,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   err_overflow
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] RST_ID = ID_W'(NREQ - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [ID_W-1:0]   rr_id;
  logic [ID_W-1:0]   rr_idx;
  logic [CW-1:0]     beat_cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Walk downward so the nearest requester after grant_id wins.
  always_comb begin
    rr_id  = grant_id;
    rr_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_idx = ID_W'((int'(grant_id) + k) % NREQ);
      if (req_valid[rr_idx]) rr_id = rr_idx;
    end
  end

  assign busy       = (state == BURST);
  assign g_valid    = req_valid[grant_id];
  assign g_last     = req_last[grant_id];
  assign fifo_wen   = busy & g_valid & ~fifo_full;
  assign fifo_wdata = busy ? data_arr[grant_id] : '0;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = ~fifo_full;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    cnt_nxt   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = BURST;
          grant_nxt = rr_id;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (fifo_wen) begin
          cnt_nxt = beat_cnt + 1'b1;
          if (g_last || beat_cnt == LAST_CNT) state_nxt = IDLE;
        end else if (!g_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      grant_id     <= RST_ID;
      beat_cnt     <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant_id     <= grant_nxt;
      beat_cnt     <= cnt_nxt;
      err_overflow <= err_overflow | fifo_overflow;
    end
  end

endmodule
